memoria_ctrl: RTL

Access controller sitting directly upstream of the JK-flip-flop word array (WORDS x DATA_W cells; each word has a select, rw and clear input and a select-gated output). It accepts read, write and clear requests over a valid/ready handshake. It sequences glitch-free one-hot word selects, rw and data toward the array, and captures read data. It returns a response over a valid/ready handshake. One request is in flight at a time.

---
 rtl/mem_ctrl_pkg.sv | 18 +
 rtl/memoria_ctrl_onehot_dec.sv | 27 ++
 rtl/memoria_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the word-array access controller.
// Holds the controller state encoding and the default geometry
// (address width, word width, number of attached words).
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 4;
    localparam int WORDS_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        CLEAR  = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/memoria_ctrl_onehot_dec.sv
// One-hot word-select decoder.
// Ports:
//   en    in   decode enable; all selects are 0 when low
//   addr  in   word address (ADDR_W)
//   sel   out  one-hot select (WORDS), never more than one bit set
//   oor   out  address is outside the attached words (addr >= WORDS)
module onehot_dec #(
    parameter int ADDR_W = 2,
    parameter int WORDS  = 4
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORDS-1:0]  sel,
    output logic              oor
);

    always_comb begin
        sel = '0;
        oor = (int'(addr) >= WORDS);
        for (int i = 0; i < WORDS; i++) begin
            if (en && !oor && (int'(addr) == i)) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memoria_ctrl.sv
// Access controller for the JK flip-flop word array.
// Accepts read/write/clear requests over valid/ready, sequences glitch-free
// word selects toward the array (data and rw are set up one full cycle before
// the select rises), captures read data and returns a response over valid/ready.
// Ports:
//   clk, reset                  clock, async active-low reset
//   req_valid/req_ready         request handshake
//   req_rw/req_addr/req_wdata   request (1 = write), address, write data
//   clr_req                     level: clear the whole array when seen in IDLE
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata/rsp_err           read data, out-of-range flag
//   mem_sel/mem_rw/mem_din      array one-hot select, rw, data in
//   mem_clear/mem_dout          array clear, OR of selected word outputs
//
// state  | meaning
// IDLE   | waiting for clr_req or a request
// SETUP  | rw/data driven toward array, selects still low
// ACCESS | one word selected for exactly one cycle
// CLEAR  | array clear pulse
// RESP   | response held until rsp_ready
module memoria_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WORDS  = WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              clr_req,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [WORDS-1:0]  mem_sel,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_clear,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [WORDS-1:0]    sel_nxt;
    logic                rw_nxt;
    logic [DATA_W-1:0]   din_nxt;
    logic                clear_nxt;
    logic                rsp_valid_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic                err_nxt;
    logic [WORDS-1:0]    dec_sel;
    logic                dec_oor;

    // Decoded during SETUP so the select register loads at the edge that
    // starts ACCESS and clears at the edge that ends it.
    onehot_dec #(
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS)
    ) u_dec (
        .en   (state == SETUP),
        .addr (addr_q),
        .sel  (dec_sel),
        .oor  (dec_oor)
    );

    assign req_ready = (state == IDLE) && !clr_req;

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_q;
        sel_nxt       = '0;
        rw_nxt        = mem_rw;
        din_nxt       = mem_din;
        clear_nxt     = 1'b0;
        rsp_valid_nxt = rsp_valid;
        rdata_nxt     = rsp_rdata;
        err_nxt       = rsp_err;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    clear_nxt = 1'b1;
                end else if (req_valid) begin
                    state_nxt = SETUP;
                    addr_nxt  = req_addr;
                    rw_nxt    = req_rw;
                    din_nxt   = req_wdata;
                end
            end
            SETUP: begin
                if (dec_oor) begin
                    state_nxt     = RESP;
                    rw_nxt        = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rdata_nxt     = '0;
                    err_nxt       = 1'b1;
                end else begin
                    state_nxt = ACCESS;
                    sel_nxt   = dec_sel;
                end
            end
            ACCESS: begin
                // Select and rw drop on the same edge that stores/captures,
                // so rw is never seen changing under an active select.
                state_nxt     = RESP;
                rw_nxt        = 1'b0;
                rsp_valid_nxt = 1'b1;
                rdata_nxt     = mem_rw ? '0 : mem_dout;
                err_nxt       = 1'b0;
            end
            CLEAR: begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
                rdata_nxt     = '0;
                err_nxt       = 1'b0;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            mem_sel   <= '0;
            mem_rw    <= 1'b0;
            mem_din   <= '0;
            mem_clear <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            mem_sel   <= sel_nxt;
            mem_rw    <= rw_nxt;
            mem_din   <= din_nxt;
            mem_clear <= clear_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_nxt;
        end
    end

endmodule
